multi_matmul_array_ctrl: RTL and testbench
==========================================

# multi_matmul_array_ctrl

Sequenced successor to the multi-matmul lane wrapper. It instantiates `TOTAL_INPUT_W` `multi_matmul` lanes that share one north operand, each with its own west operand, and adds a run-time lane-enable mask, sticky per-lane completion tracking and a run timeout. Finished lane results are captured into a holding buffer and drained one lane at a time over a valid/ready port. It sits between the BRAM read controller and the attention-score write-back path.

## Interface

**Parameters**
- `WIDTH_A`, default 16: west operand element width.
- `FRAC_WIDTH_A`, default 8: west operand fractional bits.
- `WIDTH_B`, default 16: north operand element width.
- `FRAC_WIDTH_B`, default 8: north operand fractional bits.
- `WIDTH_OUT`, default 16: result element width.
- `FRAC_WIDTH_OUT`, default 8: result fractional bits.
- `BLOCK_SIZE`, default 2; `CHUNK_SIZE`, default 4; `INNER_DIMENSION`, default 64; `TOTAL_MODULES`, default 2; `NUM_CORES_A`, default 4; `NUM_CORES_B`, default 1: passed unchanged to every lane.
- `TOTAL_INPUT_W`, default 2: lane count, 1..16.
- `TIMEOUT_CYCLES`, default 4096: maximum number of RUN cycles before the run aborts.
- Derived: `OUT_W = WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B*TOTAL_MODULES`; `LW = max(1,$clog2(TOTAL_INPUT_W))`.

**Ports**
- `clk`, in, 1: single clock.
- `rst`, in, 1: **synchronous, active-high reset**.
- `start`, in, 1: one-cycle run request.
- `lane_en`, in, `TOTAL_INPUT_W`: lane mask, sampled when `start` is accepted.
- `input_bram`, in, `WIDTH_A*CHUNK_SIZE*NUM_CORES_A` × `TOTAL_INPUT_W` (unpacked): per-lane west operand.
- `input_n`, in, `WIDTH_B*CHUNK_SIZE*NUM_CORES_B*TOTAL_MODULES`: shared north operand.
- `out_valid`, out, 1: `out_data` holds a lane result.
- `out_ready`, in, 1: downstream accepts.
- `out_data`, out, `OUT_W`: captured result of lane `out_lane`.
- `out_lane`, out, `LW`: lane index of `out_data`.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse when a run completes or aborts.
- `timeout`, out, 1: sticky error flag; cleared by the next accepted `start`.
- `lane_done`, out, `TOTAL_INPUT_W`: sticky per-lane `accumulator_done` status for the current run.

## Operation

- States: IDLE → CLEAR → RUN → CAPTURE → DRAIN → IDLE.
- **IDLE:** `start` is accepted. The block latches `lane_en` into `mask_q` and clears `lane_done`, `timeout` and the cycle counter.
  - If `lane_en` is 0, the block pulses `done` next cycle and stays in IDLE.
  - Otherwise it moves to CLEAR.
- **CLEAR:** one cycle. `reset_acc` is 1 to every lane and `en` is 0. Then moves to RUN.
- **RUN:**
  - `en` is 1 to every lane. Disabled lanes are clocked too but ignored.
  - `lane_done[i]` is set on `accumulator_done[i] & mask_q[i]`. It holds until the next start or `rst`.
  - Exit to CAPTURE when `(lane_done | ~mask_q)` is all ones.
  - The counter increments every RUN cycle. If it reaches `TIMEOUT_CYCLES` first, set `timeout`, pulse `done`, drop `en`, go to IDLE, and produce no output.
  - Completion on the same cycle the timeout is reached counts as completion; timeout is not set.
- **CAPTURE:** one cycle with `en` = 0. Register `out_multi_matmul[i]` into `buf[i]` for every enabled lane. Set the pointer to the lowest enabled lane.
- **DRAIN:**
  - `out_valid` = 1, `out_data` = `buf[ptr]`, `out_lane` = `ptr`.
  - On `out_valid & out_ready`, the pointer advances to the next enabled lane index; disabled lanes are skipped with no bubble.
  - After the highest enabled lane transfers, pulse `done` and go to IDLE.
  - `out_data` and `out_lane` must stay stable while `out_valid & ~out_ready`.
- `start` outside IDLE is ignored. `lane_en` changes outside IDLE have no effect.
- Widths are unchanged: fixed-point arithmetic stays inside the lanes, and the buffer is a plain register copy.

## Timing

- Reset values: `out_valid` 0, `out_data` 0, `out_lane` 0, `busy` 0, `done` 0, `timeout` 0, `lane_done` 0. State IDLE; `en` and `reset_acc` to the lanes are 0.
- `rst` asserted in any state returns to IDLE on the next edge, discarding buffer contents and the drain position.
- `start` at cycle T: `busy` = 1 and CLEAR at T+1; RUN from T+2.
- Last lane done seen at cycle R: CAPTURE at R+1; `out_valid` at R+2.
- Maximum drain throughput is one lane per cycle.
- `done` rises on the same edge that returns the state to IDLE; `busy` is 0 in that cycle.
- A new `start` is accepted in the cycle `done` is high.

## Test plan

- `TOTAL_INPUT_W` = 2, `lane_en` = 2'b11, `out_ready` held 1, identity north operand → two beats, `out_lane` 0 then 1, data equals the per-lane reference product, `done` on the cycle after the second beat.
- `TOTAL_INPUT_W` = 4, `lane_en` = 4'b1010, lanes finishing at different cycles → `lane_done` sets lane by lane; exactly two beats with `out_lane` 1 then 3; lanes 0 and 2 never appear.
- Backpressure: `out_ready` toggles 1,0,0,1 → no beat lost or duplicated; `out_data` and `out_lane` stable through the stalls.
- `TIMEOUT_CYCLES` = 8, one enabled lane's done forced low → `timeout` = 1 and `done` pulse after 8 RUN cycles, no `out_valid`; next `start` clears `timeout`.
- `lane_en` = 0 with `start` → `done` one cycle later; `busy` never rises.
- `rst` pulsed mid-DRAIN after one of three beats → IDLE next cycle, `out_valid` 0; a fresh run drains all three lanes from lane 0.

Source files
------------

// File: rtl/multi_matmul_array_ctrl.sv
// multi_matmul_array_ctrl: masked multi-lane matmul sequencer with timeout and valid/ready result drain

// multi_matmul: one lane, fixed-point chunk-wise products accumulated over the inner dimension
module multi_matmul #(
   parameter int WIDTH_A = 16,
   parameter int FRAC_WIDTH_A = 8,
   parameter int WIDTH_B = 16,
   parameter int FRAC_WIDTH_B = 8,
   parameter int WIDTH_OUT = 16,
   parameter int FRAC_WIDTH_OUT = 8,
   parameter int BLOCK_SIZE = 2,
   parameter int CHUNK_SIZE = 4,
   parameter int INNER_DIMENSION = 64,
   parameter int TOTAL_MODULES = 2,
   parameter int NUM_CORES_A = 4,
   parameter int NUM_CORES_B = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic reset_acc,
   input  logic en,
   input  logic [WIDTH_A*CHUNK_SIZE*NUM_CORES_A-1:0] input_w,
   input  logic [WIDTH_B*CHUNK_SIZE*NUM_CORES_B*TOTAL_MODULES-1:0] input_n,
   output logic [WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B*TOTAL_MODULES-1:0] out_multi_matmul,
   output logic accumulator_done
);
   localparam int NM = NUM_CORES_B*TOTAL_MODULES;
   localparam int OW = WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A*NM;
   localparam int PW = WIDTH_A + WIDTH_B;
   localparam int SH = FRAC_WIDTH_A + FRAC_WIDTH_B - FRAC_WIDTH_OUT;
   localparam int STEPS = INNER_DIMENSION / (CHUNK_SIZE*BLOCK_SIZE) * BLOCK_SIZE;
   localparam int CW = $clog2(STEPS + 1);
   logic [OW-1:0] sum;
   logic [CW-1:0] cnt;
   for (genvar a = 0; a < NUM_CORES_A; a++) begin : g_a
      for (genvar m = 0; m < NM; m++) begin : g_m
         for (genvar c = 0; c < CHUNK_SIZE; c++) begin : g_c
            logic signed [PW-1:0] p;
            assign p = PW'($signed(input_w[(a*CHUNK_SIZE+c)*WIDTH_A +: WIDTH_A]))
                     * PW'($signed(input_n[(m*CHUNK_SIZE+c)*WIDTH_B +: WIDTH_B]));
            assign sum[((a*NM+m)*CHUNK_SIZE+c)*WIDTH_OUT +: WIDTH_OUT] =
               out_multi_matmul[((a*NM+m)*CHUNK_SIZE+c)*WIDTH_OUT +: WIDTH_OUT] + WIDTH_OUT'(p >>> SH);
         end
      end
   end
   // accumulate one product beat per enabled cycle until the inner dimension is covered, then hold
   always_ff @(posedge clk)
      if (rst || reset_acc) begin
         out_multi_matmul <= '0;
         cnt <= '0;
         accumulator_done <= 1'b0;
      end else if (en && !accumulator_done) begin
         out_multi_matmul <= sum;
         cnt <= cnt + 1'b1;
         accumulator_done <= cnt == CW'(STEPS - 1);
      end
endmodule

module multi_matmul_array_ctrl #(
   parameter int WIDTH_A = 16,
   parameter int FRAC_WIDTH_A = 8,
   parameter int WIDTH_B = 16,
   parameter int FRAC_WIDTH_B = 8,
   parameter int WIDTH_OUT = 16,
   parameter int FRAC_WIDTH_OUT = 8,
   parameter int BLOCK_SIZE = 2,
   parameter int CHUNK_SIZE = 4,
   parameter int INNER_DIMENSION = 64,
   parameter int TOTAL_MODULES = 2,
   parameter int NUM_CORES_A = 4,
   parameter int NUM_CORES_B = 1,
   parameter int TOTAL_INPUT_W = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int IW = WIDTH_A*CHUNK_SIZE*NUM_CORES_A,
   localparam int NW = WIDTH_B*CHUNK_SIZE*NUM_CORES_B*TOTAL_MODULES,
   localparam int OUT_W = WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B*TOTAL_MODULES,
   localparam int LW = TOTAL_INPUT_W > 1 ? $clog2(TOTAL_INPUT_W) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic [TOTAL_INPUT_W-1:0] lane_en,
   input  logic [IW-1:0] input_bram [TOTAL_INPUT_W],
   input  logic [NW-1:0] input_n,
   output logic out_valid,
   input  logic out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [LW-1:0] out_lane,
   output logic busy,
   output logic done,
   output logic timeout,
   output logic [TOTAL_INPUT_W-1:0] lane_done
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, DRAIN} state_t;
   state_t state;
   logic [TOTAL_INPUT_W-1:0] mask_q, acc_done, ld_nxt;
   logic [OUT_W-1:0] lane_out [TOTAL_INPUT_W];
   logic [OUT_W-1:0] buf_q [TOTAL_INPUT_W];
   logic [TW-1:0] cnt;
   logic [LW-1:0] ptr, first, nxt;
   logic last, all_done, run_en, clr;
   for (genvar i = 0; i < TOTAL_INPUT_W; i++) begin : g_lane
      multi_matmul #(
         .WIDTH_A(WIDTH_A), .FRAC_WIDTH_A(FRAC_WIDTH_A), .WIDTH_B(WIDTH_B), .FRAC_WIDTH_B(FRAC_WIDTH_B),
         .WIDTH_OUT(WIDTH_OUT), .FRAC_WIDTH_OUT(FRAC_WIDTH_OUT), .BLOCK_SIZE(BLOCK_SIZE),
         .CHUNK_SIZE(CHUNK_SIZE), .INNER_DIMENSION(INNER_DIMENSION), .TOTAL_MODULES(TOTAL_MODULES),
         .NUM_CORES_A(NUM_CORES_A), .NUM_CORES_B(NUM_CORES_B)
      ) u_lane (
         .clk(clk),
         .rst(rst),
         .reset_acc(clr),
         .en(run_en),
         .input_w(input_bram[i]),
         .input_n(input_n),
         .out_multi_matmul(lane_out[i]),
         .accumulator_done(acc_done[i])
      );
   end
   assign run_en = state == RUN;
   assign clr = state == CLEAR;
   assign busy = state != IDLE;
   assign out_valid = state == DRAIN;
   assign out_lane = ptr;
   assign out_data = buf_q[ptr];
   assign ld_nxt = lane_done | (acc_done & mask_q);
   assign all_done = &(ld_nxt | ~mask_q);
   // lowest enabled lane, and the next enabled lane above the drain pointer
   always_comb begin
      first = '0;
      nxt = '0;
      last = 1'b1;
      for (int i = TOTAL_INPUT_W - 1; i >= 0; i--) begin
         first = mask_q[i] ? LW'(i) : first;
         nxt = (mask_q[i] && LW'(i) > ptr) ? LW'(i) : nxt;
         last = (mask_q[i] && LW'(i) > ptr) ? 1'b0 : last;
      end
   end
   // run sequencer: clear lanes, run with timeout, capture results, drain enabled lanes in order
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         mask_q <= '0;
         lane_done <= '0;
         timeout <= 1'b0;
         done <= 1'b0;
         cnt <= '0;
         ptr <= '0;
         for (int i = 0; i < TOTAL_INPUT_W; i++) buf_q[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               mask_q <= lane_en;
               lane_done <= '0;
               timeout <= 1'b0;
               cnt <= '0;
               done <= lane_en == '0;
               state <= lane_en == '0 ? IDLE : CLEAR;
            end
            CLEAR: state <= RUN;
            RUN: begin
               lane_done <= ld_nxt;
               cnt <= cnt + 1'b1;
               if (all_done) state <= CAPTURE;
               else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  timeout <= 1'b1;
                  done <= 1'b1;
                  state <= IDLE;
               end
            end
            CAPTURE: begin
               for (int i = 0; i < TOTAL_INPUT_W; i++) if (mask_q[i]) buf_q[i] <= lane_out[i];
               ptr <= first;
               state <= DRAIN;
            end
            DRAIN: if (out_ready) begin
               ptr <= last ? ptr : nxt;
               done <= last;
               state <= last ? IDLE : DRAIN;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_multi_matmul_array_ctrl.sv
// tb_multi_matmul_array_ctrl: randomized bench against an arithmetic reference of the lane products
module tb_multi_matmul_array_ctrl;
   localparam int CH = 4, NCA = 4, NCB = 1, TM = 2, W = 16, STEPS = 16, SH = 8;
   localparam int NM = NCB*TM, IW = W*CH*NCA, NW = W*CH*NM, OUT_W = W*CH*NCA*NM;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, t_start = 1'b0, b_start = 1'b0, out_ready = 1'b0;
   logic [3:0] lane_en = '0;
   logic [1:0] s_en = '0;
   logic [IW-1:0] input_bram [4];
   logic [IW-1:0] s_bram [2];
   logic [NW-1:0] input_n = '0;
   logic out_valid, busy, done, timeout;
   logic [OUT_W-1:0] out_data;
   logic [1:0] out_lane;
   logic [3:0] lane_done;
   logic t_valid, t_busy, t_done, t_timeout, t_lane;
   logic [OUT_W-1:0] t_data;
   logic [1:0] t_lane_done;
   logic b_valid, b_busy, b_done, b_timeout, b_lane;
   logic [OUT_W-1:0] b_data;
   logic [1:0] b_lane_done;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   multi_matmul_array_ctrl #(.TOTAL_INPUT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .lane_en(lane_en), .input_bram(input_bram), .input_n(input_n),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
      .busy(busy), .done(done), .timeout(timeout), .lane_done(lane_done));

   multi_matmul_array_ctrl #(.TOTAL_INPUT_W(2), .TIMEOUT_CYCLES(8)) dut_t (
      .clk(clk), .rst(rst), .start(t_start), .lane_en(s_en), .input_bram(s_bram), .input_n(input_n),
      .out_valid(t_valid), .out_ready(out_ready), .out_data(t_data), .out_lane(t_lane),
      .busy(t_busy), .done(t_done), .timeout(t_timeout), .lane_done(t_lane_done));

   multi_matmul_array_ctrl #(.TOTAL_INPUT_W(2), .TIMEOUT_CYCLES(17)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .lane_en(s_en), .input_bram(s_bram), .input_n(input_n),
      .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .out_lane(b_lane),
      .busy(b_busy), .done(b_done), .timeout(b_timeout), .lane_done(b_lane_done));

   // each output element is the truncated fixed-point product summed over the inner dimension
   function automatic logic [OUT_W-1:0] ref_lane(input logic [IW-1:0] w, input logic [NW-1:0] n);
      logic [OUT_W-1:0] r = '0;
      for (int a = 0; a < NCA; a++)
         for (int m = 0; m < NM; m++)
            for (int c = 0; c < CH; c++) begin
               logic signed [W-1:0] x, y;
               longint p;
               x = w[(a*CH+c)*W +: W];
               y = n[(m*CH+c)*W +: W];
               p = (longint'(x) * longint'(y)) >>> SH;
               r[((a*NM+m)*CH+c)*W +: W] = W'(p * STEPS);
            end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input bit ident);
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < IW/32; k++) input_bram[i][k*32 +: 32] = $urandom();
      for (int i = 0; i < 2; i++) s_bram[i] = input_bram[i];
      for (int e = 0; e < NW/W; e++) input_n[e*W +: W] = ident ? 16'h0100 : 16'($urandom());
   endtask

   task automatic launch(input logic [3:0] mask, input string nm);
      int n = 0;
      lane_en = mask;
      start = 1'b1;
      step();
      lane_en = 4'($urandom());
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %b want 1", nm, busy); end
      while (out_valid !== 1'b1 && n < 60) begin
         start = 1'($urandom());
         step();
         n++;
         if (n == 10) begin
            checks++;
            if (lane_done !== 4'b0) begin errors++; $display("FAIL %s lane_done_mid_run got %b want 0000", nm, lane_done); end
         end
      end
      start = 1'b0;
      checks++;
      if (n !== 19) begin errors++; $display("FAIL %s first_valid_latency got %0d want 19", nm, n); end
      checks++;
      if (lane_done !== mask) begin errors++; $display("FAIL %s lane_done got %b want %b", nm, lane_done, mask); end
   endtask

   task automatic drain(input logic [3:0] mask, input logic [3:0] pat, input string nm);
      int q[$];
      int k = 0;
      for (int i = 0; i < 4; i++) if (mask[i]) q.push_back(i);
      while (q.size() > 0 && k < 40) begin
         out_ready = pat[k % 4];
         k++;
         checks++;
         if (out_valid !== 1'b1 || out_lane !== 2'(q[0]) || out_data !== ref_lane(input_bram[q[0]], input_n)) begin
            errors++;
            $display("FAIL %s beat valid=%b lane=%0d want_lane=%0d data=%h want=%h", nm, out_valid, out_lane, q[0],
                     out_data, ref_lane(input_bram[q[0]], input_n));
         end
         if (out_ready) void'(q.pop_front());
         step();
      end
      out_ready = 1'b0;
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL %s beats_left got %0d want 0", nm, q.size()); end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s end done=%b busy=%b valid=%b want 1 0 0", nm, done, busy, out_valid);
      end
   endtask

   task automatic test_reset();
      load(1'b0);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset flags valid=%b busy=%b done=%b timeout=%b want 0", out_valid, busy, done, timeout);
      end
      checks++;
      if (out_data !== '0 || out_lane !== 2'd0 || lane_done !== 4'd0) begin
         errors++;
         $display("FAIL reset data lane=%0d lane_done=%b data_nonzero=%b want 0", out_lane, lane_done, |out_data);
      end
      checks++;
      if (t_valid !== 1'b0 || t_timeout !== 1'b0 || b_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_small t_valid=%b t_timeout=%b b_busy=%b want 0", t_valid, t_timeout, b_busy);
      end
   endtask

   task automatic test_all_lanes();
      load(1'b1);
      launch(4'b1111, "all");
      drain(4'b1111, 4'b1111, "all");
   endtask

   task automatic test_back_to_back();
      load(1'b0);
      launch(4'b1010, "sparse");
      drain(4'b1010, 4'b1111, "sparse");
   endtask

   task automatic test_backpressure();
      step();
      load(1'b0);
      launch(4'b1101, "bp");
      drain(4'b1101, 4'b1001, "bp");
   endtask

   task automatic test_zero_mask();
      step();
      lane_en = 4'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_mask done=%b busy=%b want 1 0", done, busy); end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_mask_after done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic test_reset_mid_drain();
      load(1'b0);
      launch(4'b0111, "rstmid");
      out_ready = 1'b1;
      checks++;
      if (out_lane !== 2'd0 || out_data !== ref_lane(input_bram[0], input_n)) begin
         errors++;
         $display("FAIL rstmid first_beat lane=%0d want 0", out_lane);
      end
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_lane !== 2'd1) begin
         errors++;
         $display("FAIL rstmid second_beat valid=%b lane=%0d want 1 1", out_valid, out_lane);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_lane !== 2'd0 || out_data !== '0) begin
         errors++;
         $display("FAIL rstmid after_rst valid=%b busy=%b lane=%0d data_nonzero=%b want 0", out_valid, busy, out_lane, |out_data);
      end
      load(1'b0);
      launch(4'b0111, "fresh");
      drain(4'b0111, 4'b1111, "fresh");
   endtask

   task automatic test_timeout();
      int n = 0;
      bit seen = 1'b0;
      step();
      load(1'b0);
      s_en = 2'b01;
      t_start = 1'b1;
      step();
      t_start = 1'b0;
      while (t_done !== 1'b1 && n < 40) begin
         seen = seen | (t_valid === 1'b1);
         step();
         n++;
      end
      checks++;
      if (n !== 9) begin errors++; $display("FAIL timeout_latency got %0d want 9", n); end
      checks++;
      if (t_timeout !== 1'b1 || t_busy !== 1'b0 || t_lane_done !== 2'b00) begin
         errors++;
         $display("FAIL timeout_flags timeout=%b busy=%b lane_done=%b want 1 0 00", t_timeout, t_busy, t_lane_done);
      end
      checks++;
      if (seen || t_valid !== 1'b0) begin errors++; $display("FAIL timeout_no_output valid_seen=%b want 0", seen); end
      t_start = 1'b1;
      step();
      t_start = 1'b0;
      checks++;
      if (t_timeout !== 1'b0 || t_busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_cleared timeout=%b busy=%b want 0 1", t_timeout, t_busy);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_tie();
      int n = 0;
      load(1'b0);
      s_en = 2'b11;
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      while (b_valid !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      checks++;
      if (n !== 19 || b_timeout !== 1'b0 || b_lane_done !== 2'b11) begin
         errors++;
         $display("FAIL tie latency=%0d timeout=%b lane_done=%b want 19 0 11", n, b_timeout, b_lane_done);
      end
      out_ready = 1'b1;
      checks++;
      if (b_lane !== 1'b0 || b_data !== ref_lane(s_bram[0], input_n)) begin
         errors++;
         $display("FAIL tie beat0 lane=%0d data=%h want=%h", b_lane, b_data, ref_lane(s_bram[0], input_n));
      end
      step();
      checks++;
      if (b_valid !== 1'b1 || b_lane !== 1'b1 || b_data !== ref_lane(s_bram[1], input_n)) begin
         errors++;
         $display("FAIL tie beat1 valid=%b lane=%0d data=%h want=%h", b_valid, b_lane, b_data, ref_lane(s_bram[1], input_n));
      end
      step();
      out_ready = 1'b0;
      checks++;
      if (b_done !== 1'b1 || b_valid !== 1'b0) begin errors++; $display("FAIL tie_done done=%b valid=%b want 1 0", b_done, b_valid); end
   endtask

   initial begin
      test_reset();
      test_all_lanes();
      test_back_to_back();
      test_backpressure();
      test_zero_mask();
      test_reset_mid_drain();
      test_timeout();
      test_tie();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
